fft_stage_r2_sdf: RTL and testbench



---
 rtl/fft_stage_r2_sdf.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_fft_stage_r2_sdf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_r2_sdf.sv
// Radix-2 DIF FFT stage with single-path delay feedback. The delay line is an
// external simple-dual-port RAM of STAGE_N/2 words. The stage emits c = a+b
// with twiddle index 0 and, H advances later, d = a-b with twiddle index j.
// Optional per-frame 1/2 scaling with rounding, saturation with a sticky flag,
// self-draining of pending d values and sticky protocol-error detection.
module fft_stage_r2_sdf #(
  parameter int DATA_WIDTH     = 16,
  parameter int STAGE_N        = 4096,
  parameter int ADDR_WIDTH     = 11,
  parameter int RAM_RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sig_start_i,
  input  logic                    sig_vld_i,
  input  logic [DATA_WIDTH-1:0]   sig_real_i,
  input  logic [DATA_WIDTH-1:0]   sig_imag_i,
  input  logic                    scale_i,
  input  logic                    inv_i,
  output logic                    sig_start_o,
  output logic                    sig_vld_o,
  output logic [DATA_WIDTH-1:0]   sig_real_o,
  output logic [DATA_WIDTH-1:0]   sig_imag_o,
  output logic [ADDR_WIDTH-1:0]   sig_tw_idx_o,
  output logic                    sig_inv_o,
  output logic                    ovf_o,
  output logic                    err_o,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [2*DATA_WIDTH-1:0] wr_data_o,
  output logic                    rd_en_o,
  output logic [ADDR_WIDTH-1:0]   rd_addr_o,
  input  logic [2*DATA_WIDTH-1:0] rd_data_i
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int L  = RAM_RD_LATENCY;
  localparam int LS = RAM_RD_LATENCY - 1;

  localparam logic [CW-1:0]        C_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]        C_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        C_HALF  = CW'(STAGE_N / 2);
  localparam logic [CW-1:0]        C_LAST  = CW'(STAGE_N - 1);
  localparam logic [AW-1:0]        A_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0]        A_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic signed [DW+1:0] X_ONE   = {{(DW+1){1'b0}}, 1'b1};
  localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

  // Optional round-half-up halving, then clamp to DW bits; MSB of result flags a clamp.
  function automatic logic [DW:0] fn_fit(input logic signed [DW+1:0] x, input logic scale);
    logic signed [DW+1:0] y;
    if (scale) begin
      y = (x + X_ONE) >>> 1'b1;
    end else begin
      y = x;
    end
    if (y > SAT_MAX) begin
      fn_fit = {1'b1, SAT_MAX[DW-1:0]};
    end else if (y < SAT_MIN) begin
      fn_fit = {1'b1, SAT_MIN[DW-1:0]};
    end else begin
      fn_fit = {1'b0, y[DW-1:0]};
    end
  endfunction

  // Frame / drain state
  logic [CW-1:0] r_cnt;
  logic          r_active;
  logic          r_fscale;
  logic          r_finv;
  logic          r_dinv;
  logic [CW-1:0] r_dcnt;
  logic [AW-1:0] r_ptr;
  logic          r_err;
  logic          r_ovf;

  // Read-latency alignment pipeline
  logic          r_p_wr    [0:LS];
  logic          r_p_sec   [0:LS];
  logic          r_p_dout  [0:LS];
  logic          r_p_st    [0:LS];
  logic          r_p_scale [0:LS];
  logic          r_p_inv   [0:LS];
  logic [DW-1:0] r_p_re    [0:LS];
  logic [DW-1:0] r_p_im    [0:LS];
  logic [AW-1:0] r_p_ptr   [0:LS];
  logic [AW-1:0] r_p_tw    [0:LS];

  // Registered outputs
  logic          r_vld_o;
  logic          r_start_o;
  logic [DW-1:0] r_re_o;
  logic [DW-1:0] r_im_o;
  logic [AW-1:0] r_tw_o;
  logic          r_inv_o;

  // Issue-side decode
  logic          w_start, w_smp, w_drop, w_restart, w_drain, w_adv;
  logic          w_sec, w_last, w_dout, w_cur_scale, w_cur_inv, w_tag_inv;
  logic [CW-1:0] w_idx;
  logic [AW-1:0] w_tw;

  // Classify this cycle: frame sample, drain-only advance, or protocol error.
  always_comb begin
    w_start   = sig_vld_i & sig_start_i;
    w_smp     = sig_vld_i & (r_active | sig_start_i);
    w_drop    = r_active & ~sig_vld_i;
    w_restart = r_active & w_start;
    if (w_start) begin
      w_idx       = C_ZERO;
      w_cur_scale = scale_i;
      w_cur_inv   = inv_i;
    end else begin
      w_idx       = r_cnt;
      w_cur_scale = r_fscale;
      w_cur_inv   = r_finv;
    end
    w_drain   = ~w_smp & ~r_active & (r_dcnt != C_ZERO);
    w_adv     = w_smp | w_drain;
    w_sec     = w_smp & w_idx[CW-1];
    w_last    = w_smp & (w_idx == C_LAST);
    w_dout    = w_adv & ~w_sec & (r_dcnt != C_ZERO);
    w_tag_inv = w_dout ? r_dinv : w_cur_inv;
    // Drain position is H - dcnt; H is 2^AW so this reduces to -dcnt mod H.
    if (w_dout) begin
      w_tw = A_ZERO - r_dcnt[AW-1:0];
    end else begin
      w_tw = A_ZERO;
    end
  end

  // Write-side butterfly on the word returned L cycles after issue
  logic signed [DW-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [DW+1:0]   w_a_re_x, w_a_im_x, w_b_re_x, w_b_im_x;
  logic [DW:0]            w_c_re, w_c_im, w_d_re, w_d_im;
  logic                   w_sat;

  // Sign-extend operands and form saturated/scaled sum and difference.
  always_comb begin
    w_a_re   = rd_data_i[2*DW-1:DW];
    w_a_im   = rd_data_i[DW-1:0];
    w_b_re   = r_p_re[LS];
    w_b_im   = r_p_im[LS];
    w_a_re_x = {{2{w_a_re[DW-1]}}, w_a_re};
    w_a_im_x = {{2{w_a_im[DW-1]}}, w_a_im};
    w_b_re_x = {{2{w_b_re[DW-1]}}, w_b_re};
    w_b_im_x = {{2{w_b_im[DW-1]}}, w_b_im};
    w_c_re   = fn_fit(w_a_re_x + w_b_re_x, r_p_scale[LS]);
    w_c_im   = fn_fit(w_a_im_x + w_b_im_x, r_p_scale[LS]);
    w_d_re   = fn_fit(w_a_re_x - w_b_re_x, r_p_scale[LS]);
    w_d_im   = fn_fit(w_a_im_x - w_b_im_x, r_p_scale[LS]);
    w_sat    = w_c_re[DW] | w_c_im[DW] | w_d_re[DW] | w_d_im[DW];
  end

  assign rd_en_o   = rst_n & w_adv;
  assign rd_addr_o = r_ptr;
  assign wr_en_o   = rst_n & r_p_wr[LS];
  assign wr_addr_o = r_p_ptr[LS];
  assign wr_data_o = r_p_sec[LS] ? {w_d_re[DW-1:0], w_d_im[DW-1:0]} : {w_b_re, w_b_im};

  // Phase counter, frame tags, drain counter, RAM pointer and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= C_ZERO;
      r_active <= 1'b0;
      r_fscale <= 1'b0;
      r_finv   <= 1'b0;
      r_dinv   <= 1'b0;
      r_dcnt   <= C_ZERO;
      r_ptr    <= A_ZERO;
      r_err    <= 1'b0;
    end else begin
      if (w_smp) begin
        if (w_last) begin
          r_cnt    <= C_ZERO;
          r_active <= 1'b0;
        end else begin
          r_cnt    <= w_idx + C_ONE;
          r_active <= 1'b1;
        end
      end else if (w_drop) begin
        r_cnt    <= C_ZERO;
        r_active <= 1'b0;
      end
      if (w_start) begin
        r_fscale <= scale_i;
        r_finv   <= inv_i;
      end
      if (w_last) begin
        r_dcnt <= C_HALF;
        r_dinv <= w_cur_inv;
      end else if (w_dout) begin
        r_dcnt <= r_dcnt - C_ONE;
      end
      if (w_adv) begin
        r_ptr <= r_ptr + A_ONE;
      end
      if (w_drop | w_restart) begin
        r_err <= 1'b1;
      end
    end
  end

  // Delay issue-time context by the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        r_p_wr[i]    <= 1'b0;
        r_p_sec[i]   <= 1'b0;
        r_p_dout[i]  <= 1'b0;
        r_p_st[i]    <= 1'b0;
        r_p_scale[i] <= 1'b0;
        r_p_inv[i]   <= 1'b0;
        r_p_re[i]    <= {DW{1'b0}};
        r_p_im[i]    <= {DW{1'b0}};
        r_p_ptr[i]   <= A_ZERO;
        r_p_tw[i]    <= A_ZERO;
      end
    end else begin
      r_p_wr[0]    <= w_smp;
      r_p_sec[0]   <= w_sec;
      r_p_dout[0]  <= w_dout;
      r_p_st[0]    <= w_sec & (w_idx == C_HALF);
      r_p_scale[0] <= w_cur_scale;
      r_p_inv[0]   <= w_tag_inv;
      r_p_re[0]    <= sig_real_i;
      r_p_im[0]    <= sig_imag_i;
      r_p_ptr[0]   <= r_ptr;
      r_p_tw[0]    <= w_tw;
      for (int i = 1; i < L; i++) begin
        r_p_wr[i]    <= r_p_wr[i-1];
        r_p_sec[i]   <= r_p_sec[i-1];
        r_p_dout[i]  <= r_p_dout[i-1];
        r_p_st[i]    <= r_p_st[i-1];
        r_p_scale[i] <= r_p_scale[i-1];
        r_p_inv[i]   <= r_p_inv[i-1];
        r_p_re[i]    <= r_p_re[i-1];
        r_p_im[i]    <= r_p_im[i-1];
        r_p_ptr[i]   <= r_p_ptr[i-1];
        r_p_tw[i]    <= r_p_tw[i-1];
      end
    end
  end

  // Register either c (second half) or a drained d word, and the sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_o   <= 1'b0;
      r_start_o <= 1'b0;
      r_re_o    <= {DW{1'b0}};
      r_im_o    <= {DW{1'b0}};
      r_tw_o    <= A_ZERO;
      r_inv_o   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (r_p_sec[LS]) begin
        r_vld_o   <= 1'b1;
        r_start_o <= r_p_st[LS];
        r_re_o    <= w_c_re[DW-1:0];
        r_im_o    <= w_c_im[DW-1:0];
        r_tw_o    <= A_ZERO;
        r_inv_o   <= r_p_inv[LS];
      end else if (r_p_dout[LS]) begin
        r_vld_o   <= 1'b1;
        r_start_o <= 1'b0;
        r_re_o    <= w_a_re;
        r_im_o    <= w_a_im;
        r_tw_o    <= r_p_tw[LS];
        r_inv_o   <= r_p_inv[LS];
      end else begin
        r_vld_o   <= 1'b0;
        r_start_o <= 1'b0;
        r_re_o    <= {DW{1'b0}};
        r_im_o    <= {DW{1'b0}};
        r_tw_o    <= A_ZERO;
        r_inv_o   <= 1'b0;
      end
      if (r_p_sec[LS] & w_sat) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign sig_vld_o    = r_vld_o;
  assign sig_start_o  = r_start_o;
  assign sig_real_o   = r_re_o;
  assign sig_imag_o   = r_im_o;
  assign sig_tw_idx_o = r_tw_o;
  assign sig_inv_o    = r_inv_o;
  assign ovf_o        = r_ovf;
  assign err_o        = r_err;

endmodule

// File: tb/tb_fft_stage_r2_sdf.sv
// Directed bench for fft_stage_r2_sdf at STAGE_N=16, L=2 with a behavioural
// two-cycle-latency RAM. Expected outputs are hand-derived per scenario.
module tb_fft_stage_r2_sdf;
  localparam int DW = 16;
  localparam int N  = 16;
  localparam int AW = 3;
  localparam int L  = 2;
  localparam int NC = 80;
  localparam int NEVER = 100000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            sig_start_i = 1'b0, sig_vld_i = 1'b0, scale_i = 1'b0, inv_i = 1'b0;
  logic [DW-1:0]   sig_real_i = '0, sig_imag_i = '0;
  logic            sig_start_o, sig_vld_o, sig_inv_o, ovf_o, err_o;
  logic [DW-1:0]   sig_real_o, sig_imag_o;
  logic [AW-1:0]   sig_tw_idx_o, wr_addr_o, rd_addr_o;
  logic            wr_en_o, rd_en_o;
  logic [2*DW-1:0] wr_data_o;
  logic [2*DW-1:0] rd_data_i = '0;

  always #5 clk = ~clk;

  fft_stage_r2_sdf #(.DATA_WIDTH(DW), .STAGE_N(N), .ADDR_WIDTH(AW), .RAM_RD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .sig_start_i(sig_start_i), .sig_vld_i(sig_vld_i),
    .sig_real_i(sig_real_i), .sig_imag_i(sig_imag_i),
    .scale_i(scale_i), .inv_i(inv_i),
    .sig_start_o(sig_start_o), .sig_vld_o(sig_vld_o),
    .sig_real_o(sig_real_o), .sig_imag_o(sig_imag_o),
    .sig_tw_idx_o(sig_tw_idx_o), .sig_inv_o(sig_inv_o),
    .ovf_o(ovf_o), .err_o(err_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i)
  );

  // Simple dual-port RAM, two-cycle read latency
  logic [2*DW-1:0] mem [0:N/2-1];
  logic [2*DW-1:0] rd_s1 = '0;
  always @(posedge clk) begin
    if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
    if (rd_en_o) rd_s1 <= mem[rd_addr_o];
    rd_data_i <= rd_s1;
  end

  int checks = 0;
  int errors = 0;

  // Stimulus and expectation tables, indexed by cycle
  logic st_vld [NC], st_start [NC], st_scale [NC], st_inv [NC];
  int   st_re [NC], st_im [NC];
  logic ex_vld [NC], ex_st [NC], ex_inv [NC];
  int   ex_re [NC], ex_im [NC], ex_tw [NC];
  logic sp_rd [NC], sp_rd_en [NC], sp_wr [NC];
  logic [AW-1:0]   sp_ra [NC], sp_wa [NC];
  logic [2*DW-1:0] sp_wd [NC];

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_tables();
    for (int c = 0; c < NC; c++) begin
      st_vld[c] = 1'b0; st_start[c] = 1'b0; st_scale[c] = 1'b0; st_inv[c] = 1'b0;
      st_re[c] = 0; st_im[c] = 0;
      ex_vld[c] = 1'b0; ex_st[c] = 1'b0; ex_inv[c] = 1'b0;
      ex_re[c] = 0; ex_im[c] = 0; ex_tw[c] = 0;
      sp_rd[c] = 1'b0; sp_rd_en[c] = 1'b0; sp_wr[c] = 1'b0;
      sp_ra[c] = '0; sp_wa[c] = '0; sp_wd[c] = '0;
    end
  endtask

  // mode 0: re=k im=0; mode 1: re=im=k; mode 2: re=32767 im=0
  task automatic put_frame(input int c0, input logic sc, input logic iv, input int mode);
    for (int k = 0; k < N; k++) begin
      st_vld[c0+k]   = 1'b1;
      st_start[c0+k] = (k == 0);
      st_scale[c0+k] = sc;
      st_inv[c0+k]   = iv;
      st_re[c0+k]    = (mode == 2) ? 32767 : k;
      st_im[c0+k]    = (mode == 1) ? k : 0;
    end
  endtask

  // Ramp result: c_j = 8+2j (scaled 4+j), d_j = -8 (scaled -4)
  task automatic exp_ramp(input int cc, input int cd, input logic iv, input logic sc, input logic with_im);
    for (int j = 0; j < N/2; j++) begin
      ex_vld[cc+j] = 1'b1; ex_st[cc+j] = (j == 0); ex_inv[cc+j] = iv; ex_tw[cc+j] = 0;
      ex_re[cc+j]  = sc ? 4 + j : 8 + 2*j;
      ex_im[cc+j]  = with_im ? ex_re[cc+j] : 0;
      ex_vld[cd+j] = 1'b1; ex_st[cd+j] = 1'b0; ex_inv[cd+j] = iv; ex_tw[cd+j] = j;
      ex_re[cd+j]  = sc ? -4 : -8;
      ex_im[cd+j]  = with_im ? ex_re[cd+j] : 0;
    end
  endtask

  task automatic run(input int ncyc, input int ovf_from, input int err_from);
    logic [DW-1:0] er, ei;
    logic [AW-1:0] et;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      sig_vld_i   = st_vld[c];
      sig_start_i = st_start[c];
      scale_i     = st_scale[c];
      inv_i       = st_inv[c];
      sig_real_i  = DW'(st_re[c]);
      sig_imag_i  = DW'(st_im[c]);
      #1;
      chk("vld", c, 32'(sig_vld_o), 32'(ex_vld[c]));
      chk("ovf", c, 32'(ovf_o), 32'(c >= ovf_from));
      chk("err", c, 32'(err_o), 32'(c >= err_from));
      if (ex_vld[c]) begin
        er = DW'(ex_re[c]); ei = DW'(ex_im[c]); et = AW'(ex_tw[c]);
        chk("re", c, 32'(sig_real_o), 32'(er));
        chk("im", c, 32'(sig_imag_o), 32'(ei));
        chk("tw", c, 32'(sig_tw_idx_o), 32'(et));
        chk("start", c, 32'(sig_start_o), 32'(ex_st[c]));
        chk("inv", c, 32'(sig_inv_o), 32'(ex_inv[c]));
      end
      if (sp_rd[c]) begin
        chk("rd_en", c, 32'(rd_en_o), 32'(sp_rd_en[c]));
        if (sp_rd_en[c]) chk("rd_addr", c, 32'(rd_addr_o), 32'(sp_ra[c]));
      end
      if (sp_wr[c]) begin
        chk("wr_en", c, 32'(wr_en_o), 32'd1);
        chk("wr_addr", c, 32'(wr_addr_o), 32'(sp_wa[c]));
        chk("wr_data", c, wr_data_o, sp_wd[c]);
      end
    end
    @(negedge clk);
    sig_vld_i = 1'b0; sig_start_i = 1'b0; scale_i = 1'b0; inv_i = 1'b0;
    sig_real_i = '0; sig_imag_i = '0;
  endtask

  // Reset with a live-looking input, check everything is quiet, then release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sig_vld_i = 1'b1; sig_start_i = 1'b1; sig_real_i = 16'h1234;
    #1;
    chk("rst_vld", -1, 32'(sig_vld_o), 32'd0);
    chk("rst_start", -1, 32'(sig_start_o), 32'd0);
    chk("rst_re", -1, 32'(sig_real_o), 32'd0);
    chk("rst_im", -1, 32'(sig_imag_o), 32'd0);
    chk("rst_tw", -1, 32'(sig_tw_idx_o), 32'd0);
    chk("rst_inv", -1, 32'(sig_inv_o), 32'd0);
    chk("rst_ovf", -1, 32'(ovf_o), 32'd0);
    chk("rst_err", -1, 32'(err_o), 32'd0);
    chk("rst_rd_en", -1, 32'(rd_en_o), 32'd0);
    chk("rst_wr_en", -1, 32'(wr_en_o), 32'd0);
    repeat (2) @(negedge clk);
    sig_vld_i = 1'b0; sig_start_i = 1'b0; sig_real_i = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < N/2; a++) mem[a] = '0;

    // 1. Unscaled ramp with RAM-port spot checks
    do_reset();
    clear_tables();
    put_frame(0, 1'b0, 1'b0, 0);
    exp_ramp(11, 19, 1'b0, 1'b0, 1'b0);
    sp_rd[0] = 1'b1; sp_rd_en[0] = 1'b1; sp_ra[0] = 3'd0;
    sp_rd[5] = 1'b1; sp_rd_en[5] = 1'b1; sp_ra[5] = 3'd5;
    sp_rd[25] = 1'b1; sp_rd_en[25] = 1'b0;
    sp_wr[3] = 1'b1; sp_wa[3] = 3'd1; sp_wd[3] = 32'h0001_0000;
    sp_wr[10] = 1'b1; sp_wa[10] = 3'd0; sp_wd[10] = 32'hFFF8_0000;
    run(32, NEVER, NEVER);

    // 2. Scaled ramp
    do_reset();
    clear_tables();
    put_frame(0, 1'b1, 1'b0, 0);
    exp_ramp(11, 19, 1'b0, 1'b1, 1'b0);
    run(32, NEVER, NEVER);

    // 3. Saturation: c clamps to 32767, d = 0, ovf sticky from cycle 11
    do_reset();
    clear_tables();
    put_frame(0, 1'b0, 1'b0, 2);
    for (int j = 0; j < N/2; j++) begin
      ex_vld[11+j] = 1'b1; ex_st[11+j] = (j == 0); ex_re[11+j] = 32767;
      ex_vld[19+j] = 1'b1; ex_tw[19+j] = j; ex_re[19+j] = 0;
    end
    run(32, 11, NEVER);

    // 4. Back-to-back frames, second one inverse with ramp on both axes
    do_reset();
    clear_tables();
    put_frame(0, 1'b0, 1'b0, 0);
    put_frame(16, 1'b0, 1'b1, 1);
    exp_ramp(11, 19, 1'b0, 1'b0, 1'b0);
    exp_ramp(27, 35, 1'b1, 1'b0, 1'b1);
    run(46, NEVER, NEVER);

    // 5. Self-drain with a gap before the next frame
    do_reset();
    clear_tables();
    put_frame(0, 1'b0, 1'b0, 0);
    put_frame(40, 1'b0, 1'b1, 0);
    exp_ramp(11, 19, 1'b0, 1'b0, 1'b0);
    exp_ramp(51, 59, 1'b1, 1'b0, 1'b0);
    run(70, NEVER, NEVER);

    // 6. Valid drops at sample 5; later stray valids without start are ignored
    do_reset();
    clear_tables();
    for (int c = 0; c < 5; c++) begin
      st_vld[c] = 1'b1; st_start[c] = (c == 0); st_re[c] = c;
    end
    for (int c = 10; c < 13; c++) begin
      st_vld[c] = 1'b1; st_re[c] = 77;
    end
    run(30, NEVER, 6);

    // 7. Start mid-frame restarts at sample 0
    do_reset();
    clear_tables();
    for (int c = 0; c < 3; c++) begin
      st_vld[c] = 1'b1; st_start[c] = (c == 0); st_re[c] = 100 + c;
    end
    put_frame(3, 1'b0, 1'b0, 0);
    exp_ramp(14, 22, 1'b0, 1'b0, 1'b0);
    run(32, NEVER, 4);

    // 8. Reset mid-drain, then the first scenario again
    do_reset();
    clear_tables();
    put_frame(0, 1'b0, 1'b0, 0);
    exp_ramp(11, 19, 1'b0, 1'b0, 1'b0);
    run(22, NEVER, NEVER);
    do_reset();
    run(32, NEVER, NEVER);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
